// File: rtl/countdown_display_pkg.sv
// Shared definitions for the countdown display: FSM states, glyph codes,
// segment patterns and the tens/units split used by the scan mux.
package countdown_display_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned GLYPH_W    = 5;
    localparam int unsigned SEG_W      = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    // Glyph codes 0..9 are the decimal digits themselves
    localparam logic [GLYPH_W-1:0] GL_ONE   = 5'd1;
    localparam logic [GLYPH_W-1:0] GL_C     = 5'd10;
    localparam logic [GLYPH_W-1:0] GL_E     = 5'd11;
    localparam logic [GLYPH_W-1:0] GL_N     = 5'd12;
    localparam logic [GLYPH_W-1:0] GL_D     = 5'd13;
    localparam logic [GLYPH_W-1:0] GL_BLANK = 5'd14;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_C     = 7'h39;
    localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_N     = 7'h54;
    localparam logic [SEG_W-1:0] SEG_D     = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    typedef struct packed {
        logic       tens;
        logic [3:0] units;
    } bcd_t;

    // Values are 0..15, so a single compare-and-subtract yields tens/units
    function automatic bcd_t to_bcd(input logic [3:0] value);
        bcd_t r;
        if (value >= 4'd10) begin
            r.tens  = 1'b1;
            r.units = value - 4'd10;
        end else begin
            r.tens  = 1'b0;
            r.units = value;
        end
        return r;
    endfunction

endpackage

// File: rtl/countdown_display_seg7_decoder.sv
// Glyph code to active-high 7-segment pattern (bit0 = a .. bit6 = g).
module countdown_display_seg7_decoder
    import countdown_display_pkg::*;
(
    input  logic [GLYPH_W-1:0] glyph,
    output logic [SEG_W-1:0]   seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (glyph)
            5'd0:    seg_c = SEG_0;
            5'd1:    seg_c = SEG_1;
            5'd2:    seg_c = SEG_2;
            5'd3:    seg_c = SEG_3;
            5'd4:    seg_c = SEG_4;
            5'd5:    seg_c = SEG_5;
            5'd6:    seg_c = SEG_6;
            5'd7:    seg_c = SEG_7;
            5'd8:    seg_c = SEG_8;
            5'd9:    seg_c = SEG_9;
            GL_C:    seg_c = SEG_C;
            GL_E:    seg_c = SEG_E;
            GL_N:    seg_c = SEG_N;
            GL_D:    seg_c = SEG_D;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/countdown_display.sv
// Multiplexed 8-digit display of the countdown: live seconds while counting,
// a blinking "End" banner for a fixed hold after timeout, blank when idle.
module countdown_display
    import countdown_display_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 25_000_000,
    parameter int unsigned SCAN_HZ    = 1000,
    parameter int unsigned BLINK_HZ   = 2,
    parameter int unsigned EXP_HOLD_S = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic                  i_active,
    input  logic [3:0]            i_time_val,
    input  logic                  i_timeout,
    output logic [7:0]            o_seg,
    output logic [NUM_DIGITS-1:0] o_an
);

    localparam int unsigned SCAN_DIV  = CLK_FREQ / SCAN_HZ;
    localparam int unsigned BLINK_DIV = CLK_FREQ / (2 * BLINK_HZ);
    localparam int unsigned SCAN_W    = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int unsigned BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned SEC_W     = (CLK_FREQ  > 1) ? $clog2(CLK_FREQ)  : 1;
    localparam int unsigned HOLD_W    = 4;

    state_t              state;
    state_t              state_nxt;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [IDX_W-1:0]    idx;
    logic [BLINK_W-1:0]  blink_cnt;
    logic                blink_on;
    logic [SEC_W-1:0]    hold_cyc;
    logic [HOLD_W-1:0]   hold_sec;
    logic                scan_tick;
    logic                hold_done;
    logic                blink_eff;
    bcd_t                bcd;
    logic [GLYPH_W-1:0]  glyph;
    logic [SEG_W-1:0]    seg_c;

    assign scan_tick = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign hold_done = (hold_cyc == SEC_W'(CLK_FREQ - 1)) &&
                       (hold_sec == HOLD_W'(EXP_HOLD_S - 1));
    // Phase counters only run in EXPIRED; entering from COUNT starts with "on"
    assign blink_eff = (state != ST_EXPIRED) || blink_on;
    assign bcd       = to_bcd(i_time_val);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; restart wins over everything including a same-cycle timeout
    always_comb begin
        state_nxt = state;
        if (i_start) begin
            state_nxt = ST_COUNT;
        end else begin
            case (state)
                ST_IDLE:    if (i_active) state_nxt = ST_COUNT;
                ST_COUNT: begin
                    if (i_timeout)     state_nxt = ST_EXPIRED;
                    else if (!i_active) state_nxt = ST_IDLE;
                end
                ST_EXPIRED: if (hold_done) state_nxt = ST_IDLE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    // Scan divider and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_tick) begin
            scan_cnt <= '0;
            idx      <= idx + IDX_W'(1);
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    // Blink phase and banner hold timer, cleared whenever not in EXPIRED
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
            hold_cyc  <= '0;
            hold_sec  <= '0;
        end else if (state == ST_EXPIRED) begin
            if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
            if (hold_cyc == SEC_W'(CLK_FREQ - 1)) begin
                hold_cyc <= '0;
                hold_sec <= hold_sec + HOLD_W'(1);
            end else begin
                hold_cyc <= hold_cyc + SEC_W'(1);
            end
        end else begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
            hold_cyc  <= '0;
            hold_sec  <= '0;
        end
    end

    // Glyph for the digit being scanned, in the state being entered
    always_comb begin
        glyph = GL_BLANK;
        case (state_nxt)
            ST_COUNT: begin
                case (idx)
                    3'd0:    glyph = {1'b0, bcd.units};
                    3'd1:    glyph = bcd.tens ? GL_ONE : GL_BLANK;
                    3'd7:    glyph = GL_C;
                    default: glyph = GL_BLANK;
                endcase
            end
            ST_EXPIRED: begin
                if (blink_eff) begin
                    case (idx)
                        3'd2:    glyph = GL_E;
                        3'd1:    glyph = GL_N;
                        3'd0:    glyph = GL_D;
                        default: glyph = GL_BLANK;
                    endcase
                end
            end
            default: glyph = GL_BLANK;
        endcase
    end

    countdown_display_seg7_decoder u_dec (
        .glyph (glyph),
        .seg_c (seg_c)
    );

    // Output registers: blank as soon as IDLE is entered, else load per scan tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_an  <= '0;
            o_seg <= '0;
        end else if (state_nxt == ST_IDLE) begin
            o_an  <= '0;
            o_seg <= '0;
        end else if (scan_tick) begin
            o_an  <= NUM_DIGITS'(1) << idx;
            o_seg <= {1'b0, seg_c};
        end
    end

endmodule

// File: tb/tb_countdown_display.sv
// Randomized self-checking bench for countdown_display against a cycle-level
// behavioural model of the display rules.
module tb_countdown_display;

    localparam int unsigned CLK_FREQ   = 1000;
    localparam int unsigned SCAN_HZ    = 100;
    localparam int unsigned BLINK_HZ   = 5;
    localparam int unsigned EXP_HOLD_S = 2;
    localparam int SCAN_DIV  = CLK_FREQ / SCAN_HZ;
    localparam int BLINK_DIV = CLK_FREQ / (2 * BLINK_HZ);
    localparam int HOLD_CYC  = CLK_FREQ * EXP_HOLD_S;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_active = 1'b0;
    logic       i_timeout = 1'b0;
    logic [3:0] i_time_val = 4'd0;
    logic [7:0] o_seg;
    logic [7:0] o_an;

    always #5 clk = ~clk;

    countdown_display #(
        .CLK_FREQ   (CLK_FREQ),
        .SCAN_HZ    (SCAN_HZ),
        .BLINK_HZ   (BLINK_HZ),
        .EXP_HOLD_S (EXP_HOLD_S)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (i_start),
        .i_active   (i_active),
        .i_time_val (i_time_val),
        .i_timeout  (i_timeout),
        .o_seg      (o_seg),
        .o_an       (o_an)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Model state: 0 idle, 1 counting, 2 banner
    int         m_st, m_age, m_n, m_idx;
    logic [7:0] m_an, m_seg;
    logic [7:0] dig_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    function automatic logic [7:0] glyph_seg(input int st, input int idx, input int tv, input bit on);
        if (st == 1) begin
            if (idx == 0) return dig_tab[tv % 10];
            if (idx == 1) return (tv >= 10) ? dig_tab[1] : 8'h00;
            if (idx == 7) return 8'h39;
        end else if (st == 2 && on) begin
            if (idx == 2) return 8'h79;
            if (idx == 1) return 8'h54;
            if (idx == 0) return 8'h5E;
        end
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_st = 0; m_age = 0; m_n = 0; m_idx = 0; m_an = 8'h00; m_seg = 8'h00;
    endtask

    task automatic model_edge();
        bit tick;
        bit on;
        int nxt;
        tick = (m_n % SCAN_DIV) == SCAN_DIV - 1;
        m_n++;
        on  = (m_st != 2) || ((m_age / BLINK_DIV) % 2 == 0);
        nxt = m_st;
        if (m_st == 2) m_age++;
        if (i_start)                         nxt = 1;
        else if (m_st == 0 && i_active)      nxt = 1;
        else if (m_st == 1 && i_timeout)     nxt = 2;
        else if (m_st == 1 && !i_active)     nxt = 0;
        else if (m_st == 2 && m_age == HOLD_CYC) nxt = 0;
        if (nxt == 2 && m_st != 2) m_age = 0;
        if (nxt == 0) begin
            m_an  = 8'h00;
            m_seg = 8'h00;
        end else if (tick) begin
            m_an  = 8'(1 << m_idx);
            m_seg = glyph_seg(nxt, m_idx, int'(i_time_val), on);
        end
        if (tick) m_idx = (m_idx + 1) % 8;
        m_st = nxt;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("an", 32'(o_an), 32'(m_an));
        check("seg", 32'(o_seg), 32'(m_seg));
        i_start   = 1'b0;
        i_timeout = 1'b0;
    endtask

    task automatic run(input int k);
        repeat (k) cycle();
    endtask

    initial begin
        int k;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", 32'(o_an), 32'h0);
        check("rst_seg", 32'(o_seg), 32'h0);
        #2 rst_n = 1'b1;

        // Idle with no session
        run(40);

        // Count from 12, then the 10 -> 9 step
        i_time_val = 4'd12; i_active = 1'b1; i_start = 1'b1;
        run(100);
        i_time_val = 4'd10; run(80);
        i_time_val = 4'd9;  run(80);

        // Timeout: banner held exactly HOLD_CYC cycles with i_active still high
        i_time_val = 4'($urandom_range(0, 15));
        run(30);
        i_timeout = 1'b1;
        cycle();
        k = 0;
        do begin
            cycle();
            k++;
        end while (o_an != 8'h00 && k < 3000);
        check("exp_len", 32'(k), 32'(HOLD_CYC));

        // Restart and timeout together: stays counting
        run(20);
        i_start = 1'b1; i_timeout = 1'b1;
        cycle();
        run(100);

        // Session drop goes blank on the next cycle
        i_active = 1'b0;
        cycle();
        check("drop_an", 32'(o_an), 32'h0);
        run(20);

        // Asynchronous reset in the middle of the banner
        i_active = 1'b1;
        run(15);
        i_timeout = 1'b1;
        cycle();
        run(1234);
        #3 rst_n = 1'b0;
        #1;
        check("arst_an", 32'(o_an), 32'h0);
        check("arst_seg", 32'(o_seg), 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0)  i_start = 1'b1;
            if ($urandom_range(0, 49) == 0)  i_timeout = 1'b1;
            if ($urandom_range(0, 149) == 0) i_active = ~i_active;
            if ($urandom_range(0, 36) == 0)  i_time_val = 4'($urandom_range(0, 15));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
